// File: rtl/idct_block_stream.sv
// idct_block_stream: beat-stream to 64-element block adapter around a fixed-latency parallel IDCT kernel
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input beat handshake, in_data holds LANES elements per beat
//   out_valid/out_ready : output beat handshake, out_data same packing, out_last marks a block's final beat
//   k_x / k_out         : flat parallel buses to/from the kernel (element i at [i*DATA_W +: DATA_W])
//   busy                : a block is staged, in flight or buffered
module idct_block_stream #(
  parameter int DATA_W         = 16,
  parameter int BLK            = 64,
  parameter int LANES          = 1,
  parameter int KERNEL_LATENCY = 29,
  parameter int OUT_BUFS       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic [BLK*DATA_W-1:0]   k_x,
  input  logic [BLK*DATA_W-1:0]   k_out,
  output logic                    busy
);
  localparam int BEATS  = BLK / LANES;
  localparam int BEAT_W = LANES * DATA_W;
  localparam int BW     = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PW     = OUT_BUFS > 1 ? $clog2(OUT_BUFS) : 1;
  localparam int CW     = $clog2(OUT_BUFS + 1);
  logic [BLK*DATA_W-1:0]     stage_q, stage_d;
  logic [BLK*DATA_W-1:0]     buf_q [OUT_BUFS];
  logic [BLK*DATA_W-1:0]     buf_d [OUT_BUFS];
  logic [BW-1:0]             in_beat_q, in_beat_d, out_beat_q, out_beat_d;
  logic                      full_q, full_d;
  logic [CW-1:0]             credits_q, credits_d;
  logic [KERNEL_LATENCY-1:0] sr_q, sr_d;
  logic [OUT_BUFS-1:0]       occ_q, occ_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                      launch, in_fire, in_last, capture, out_fire, out_done;
  assign k_x = stage_q;
  always_comb begin
    // a credit reserves an output buffer for the block's result before it enters the kernel
    launch     = full_q && credits_q != '0;
    in_ready   = !rst && (!full_q || launch);
    in_fire    = in_valid && in_ready;
    in_last    = in_beat_q == BW'(BEATS - 1);
    capture    = sr_q[KERNEL_LATENCY-1];
    out_valid  = occ_q[rd_ptr_q];
    out_last   = out_valid && out_beat_q == BW'(BEATS - 1);
    out_fire   = out_valid && out_ready;
    out_done   = out_fire && out_last;
    out_data   = '0;
    for (int b = 0; b < BEATS; b++)
      if (out_valid && out_beat_q == BW'(b)) out_data = buf_q[rd_ptr_q][b*BEAT_W +: BEAT_W];
    // staging is written at the clock edge, so the kernel still sees the launched block this cycle
    stage_d = stage_q;
    for (int b = 0; b < BEATS; b++)
      if (in_fire && in_beat_q == BW'(b)) stage_d[b*BEAT_W +: BEAT_W] = in_data;
    in_beat_d  = in_fire ? (in_last ? '0 : in_beat_q + BW'(1)) : in_beat_q;
    full_d     = (full_q && !launch) || (in_fire && in_last);
    sr_d       = (sr_q << 1) | KERNEL_LATENCY'(launch);
    buf_d      = buf_q;
    if (capture) buf_d[wr_ptr_q] = k_out;
    wr_ptr_d   = capture ? (wr_ptr_q == PW'(OUT_BUFS - 1) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d   = out_done ? (rd_ptr_q == PW'(OUT_BUFS - 1) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    out_beat_d = out_fire ? (out_last ? '0 : out_beat_q + BW'(1)) : out_beat_q;
    occ_d      = occ_q;
    if (out_done) occ_d[rd_ptr_q] = 1'b0;
    if (capture) occ_d[wr_ptr_q] = 1'b1;
    credits_d  = credits_q + CW'(out_done) - CW'(launch);
    busy       = full_q || in_beat_q != '0 || credits_q != CW'(OUT_BUFS);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q    <= '0;
      for (int i = 0; i < OUT_BUFS; i++) buf_q[i] <= '0;
      in_beat_q  <= '0;
      out_beat_q <= '0;
      full_q     <= 1'b0;
      credits_q  <= CW'(OUT_BUFS);
      sr_q       <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      stage_q    <= stage_d;
      buf_q      <= buf_d;
      in_beat_q  <= in_beat_d;
      out_beat_q <= out_beat_d;
      full_q     <= full_d;
      credits_q  <= credits_d;
      sr_q       <= sr_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end
  a_credits: assert property (@(posedge clk) disable iff (rst) credits_q <= CW'(OUT_BUFS));
  a_capture: assert property (@(posedge clk) disable iff (rst) !(capture && occ_q[wr_ptr_q]));
endmodule

// File: tb/tb_idct_block_stream.sv
// tb_idct_block_stream: randomized and directed checks of idct_block_stream against a block-level model
module tb_idct_block_stream;
  localparam int KL = 29;
  logic clk, rst;
  logic in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [15:0] in_data, out_data;
  logic [1023:0] k_x, k_out;
  logic in4_valid, in4_ready, out4_valid, out4_ready, out4_last, busy4;
  logic [63:0] in4_data, out4_data;
  logic [1023:0] k4_x, k4_out;
  logic [1023:0] kp [KL];
  logic [1023:0] kp4 [KL];
  logic [15:0] in_q [$];
  logic [16:0] exp_q [$];
  int last_cyc [$];
  int checks = 0, failures = 0;
  int cyc, acc_cnt, out_cnt, first_acc, first_ov, stall_cnt;
  bit hold_prev;
  logic [16:0] hold_v;
  logic [1023:0] ramp, blk, e4;
  idct_block_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .k_x(k_x), .k_out(k_out), .busy(busy));
  idct_block_stream #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data),
    .out_valid(out4_valid), .out_ready(out4_ready), .out_data(out4_data), .out_last(out4_last),
    .k_x(k4_x), .k_out(k4_out), .busy(busy4));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [1023:0] kfun(input logic [1023:0] x);
    logic [1023:0] r;
    for (int i = 0; i < 64; i++) r[i*16 +: 16] = 16'(3 * x[i*16 +: 16] + x[(63 - i)*16 +: 16]);
    return r;
  endfunction
  always @(posedge clk) begin
    kp[0]  <= kfun(k_x);
    kp4[0] <= kfun(k4_x);
    for (int i = 1; i < KL; i++) begin
      kp[i]  <= kp[i-1];
      kp4[i] <= kp4[i-1];
    end
  end
  assign k_out  = kp[KL-1];
  assign k4_out = kp4[KL-1];
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic push_blk(input logic [1023:0] b);
    logic [1023:0] e;
    e = kfun(b);
    for (int i = 0; i < 64; i++) begin
      in_q.push_back(b[i*16 +: 16]);
      exp_q.push_back({i == 63, e[i*16 +: 16]});
    end
  endtask
  task automatic clr_stats();
    cyc = 0; acc_cnt = 0; out_cnt = 0; first_acc = -1; first_ov = -1; stall_cnt = 0;
    last_cyc.delete();
  endtask
  // vmode/rmode: 0 = low, 1 = high, 2 = random 50%
  task automatic step(input int vmode, input int rmode);
    logic [16:0] e;
    @(negedge clk);
    in_valid  = in_q.size() != 0 && (vmode == 2 ? $urandom_range(1, 0) == 1 : vmode == 1);
    in_data   = in_q.size() != 0 ? in_q[0] : '0;
    out_ready = rmode == 2 ? $urandom_range(1, 0) == 1 : rmode == 1;
    #1;
    if (hold_prev) begin
      chk("hold_valid", 80'(out_valid), 1);
      chk("hold_data", 80'({out_last, out_data}), 80'(hold_v));
    end
    hold_prev = out_valid && !out_ready;
    hold_v    = {out_last, out_data};
    if (in_valid && !in_ready) stall_cnt++;
    if (in_valid && in_ready) begin
      void'(in_q.pop_front());
      if (first_acc < 0) first_acc = cyc;
      acc_cnt++;
    end
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && out_ready) begin
      chk("beat_expected", 80'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_beat", 80'({out_last, out_data}), 80'(e));
      end
      if (out_last) last_cyc.push_back(cyc);
      out_cnt++;
    end
    cyc++;
  endtask
  task automatic drain(input int vmode, input int rmode, input int bound);
    for (int c = 0; c < bound && (in_q.size() != 0 || exp_q.size() != 0); c++) step(vmode, rmode);
    chk("drain_in", in_q.size(), 0);
    chk("drain_out", exp_q.size(), 0);
  endtask
  initial begin
    int idx4, f4;
    for (int i = 0; i < 64; i++) ramp[i*16 +: 16] = 16'(i);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in4_valid = 1'b0; in4_data = '0; out4_ready = 1'b1;
    hold_prev = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 80'(in_ready), 0);
    chk("rst_out_valid", 80'(out_valid), 0);
    chk("rst_out_last", 80'(out_last), 0);
    chk("rst_out_data", 80'(out_data), 0);
    chk("rst_k_x", 80'(|k_x), 0);
    chk("rst_busy", 80'(busy), 0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 80'(in_ready), 1);
    // single ramp block, latency from first accepted beat
    clr_stats();
    push_blk(ramp);
    drain(1, 1, 400);
    chk("ramp_latency", 80'(first_ov - first_acc), 94);
    step(0, 1);
    chk("ramp_busy_idle", 80'(busy), 0);
    // four back-to-back blocks
    clr_stats();
    repeat (4) push_blk(ramp);
    drain(1, 1, 800);
    chk("b2b_stalls", stall_cnt, 0);
    chk("b2b_blocks", last_cyc.size(), 4);
    chk("b2b_first", 80'(first_ov - first_acc), 94);
    for (int i = 1; i < 4 && i < last_cyc.size(); i++) chk("b2b_spacing", 80'(last_cyc[i] - last_cyc[i-1]), 64);
    // output backpressure: two blocks launched, third staged, fourth held off
    clr_stats();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 64; i++) blk[i*16 +: 16] = 16'($urandom);
      push_blk(blk);
    end
    repeat (300) step(1, 0);
    chk("bp_accepted", acc_cnt, 192);
    chk("bp_in_ready", 80'(in_ready), 0);
    chk("bp_no_output", out_cnt, 0);
    chk("bp_busy", 80'(busy), 1);
    drain(1, 1, 1200);
    chk("bp_blocks_out", last_cyc.size(), 4);
    // reset with one block in flight and a partial block staged
    clr_stats();
    push_blk(ramp);
    push_blk(ramp);
    repeat (80) step(1, 1);
    chk("mid_accepted", acc_cnt, 80);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1 chk("mid_rst_in_ready", 80'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    in_q.delete(); exp_q.delete(); hold_prev = 1'b0;
    clr_stats();
    repeat (100) step(0, 1);
    chk("mid_no_out_valid", 80'(first_ov), 80'(-1));
    chk("mid_busy", 80'(busy), 0);
    clr_stats();
    push_blk(ramp);
    drain(1, 1, 400);
    chk("mid_fresh_latency", 80'(first_ov - first_acc), 94);
    // random valid/ready over 20 random blocks
    clr_stats();
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 64; i++) blk[i*16 +: 16] = 16'($urandom);
      push_blk(blk);
    end
    drain(2, 2, 12000);
    chk("rand_blocks_out", last_cyc.size(), 20);
    // four lanes per beat
    e4 = kfun(ramp);
    idx4 = 0; f4 = -1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      in4_valid = c < 16;
      in4_data  = ramp[(c % 16)*64 +: 64];
      #1;
      if (c < 16) chk("l4_in_ready", 80'(in4_ready), 1);
      if (out4_valid) begin
        if (f4 < 0) f4 = c;
        if (idx4 < 16) chk("l4_out_beat", 80'({out4_last, out4_data}), 80'({idx4 == 15, e4[idx4*64 +: 64]}));
        idx4++;
      end
    end
    chk("l4_first_out", 80'(f4), 46);
    chk("l4_beats", idx4, 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/idct_block_stream.md
# idct_block_stream

Streaming adapter around the fully parallel, fixed-latency 8x8 `IDCT` kernel. It converts a valid/ready beat stream of coefficients into full 64-element blocks and launches each block into the kernel. It captures the kernel result after a parametrised latency and re-serialises it onto a valid/ready output stream. Credit-based buffering lets back-to-back blocks and output backpressure work without stalling the free-running kernel.

## Interface
Parameters:
- `DATA_W`, 16: width of one signed coefficient/sample.
- `BLK`, 64: elements per block (kernel port count).
- `LANES`, 1: elements per stream beat; must divide `BLK`.
- `KERNEL_LATENCY`, 29: kernel cycles from input to result.
- `OUT_BUFS`, 2: result block buffers (≥1).

Ports (one clock `clk`; reset `rst` asynchronous, active-high):
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  async active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  `LANES*DATA_W`  lane j = element `b*LANES+j` of the current block, bits `[j*DATA_W +: DATA_W]`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  sink accepts beat.
- `out_data`  out  `LANES*DATA_W`  same lane packing as input.
- `out_last`  out  1  final beat of a block.
- `k_x`  out  `BLK*DATA_W`  flat bus to kernel `x0..x63` (element i at `[i*DATA_W +: DATA_W]`).
- `k_out`  in  `BLK*DATA_W`  flat bus from kernel `out0..out63`.
- `busy`  out  1  any block in staging, in flight, or buffered.

## Operation
- Staging: a `BLK`-element register that drives `k_x` directly. Beat counter `in_beat` counts 0..`BLK/LANES-1`. Each accepted beat writes its `LANES` elements. The final beat sets `full`.
- `in_ready = !full || launch`. In a launch cycle, beat 0 of the next block can be accepted. It is written at the end of that cycle, after the kernel has sampled.
- Launch: in a cycle where `full && credits > 0`, assert internal `launch`, clear `full`, and decrement `credits`.
- In-flight tracking: `KERNEL_LATENCY`-bit shift register fed by `launch`. When the tap fires, capture `k_out` into buffer `wr_ptr` and advance `wr_ptr` modulo `OUT_BUFS`.
- `credits` resets to `OUT_BUFS`:
  - decrements on launch;
  - increments on the handshake of an `out_last` beat;
  - is unchanged when both happen in the same cycle.
  - `credits` never exceeds `OUT_BUFS` or goes below 0. An assertion is required.
- Output: `out_valid` is high while buffer `rd_ptr` is occupied. `out_data` presents lanes of beat `out_beat`. `out_last` = (`out_beat == BLK/LANES-1`) && `out_valid`. On handshake, `out_beat` increments. On the last beat, `out_beat` wraps to 0, `rd_ptr` advances, and the buffer is freed.
- Credits guarantee a free buffer at every capture; the kernel is never stalled.
- `out_data`/`out_last` hold stable while `out_valid && !out_ready`.
- `busy = full || in_beat!=0 || credits!=OUT_BUFS`.
- Reset (including mid-operation): clears `in_beat`, `full`, the shift register, pointers and occupancy. `credits` returns to `OUT_BUFS`. In-flight and buffered results are discarded; later kernel outputs are ignored.

## Timing
- Reset values: `in_ready`=0 while `rst` high, then 1. `out_valid`=0, `out_last`=0, `out_data`=0, `k_x`=0, `busy`=0.
- Kernel result for a block launched in cycle L is present on `k_out` in cycle L+`KERNEL_LATENCY` and captured at the end of that cycle. `out_valid` rises in cycle L+`KERNEL_LATENCY`+1.
- Defaults, first beat accepted in cycle 0, continuous input:
  - last input beat in cycle 63;
  - launch in cycle 64;
  - first output beat in cycle 94.
- Input-to-output latency for element 0 = `BLK/LANES` + `KERNEL_LATENCY` + 1 cycles.
- Sustained throughput with `out_ready`=1 and `OUT_BUFS`≥2: one block per `BLK/LANES` cycles, no input bubbles.
- With `credits`=0 and `full`: `in_ready`=0 until the cycle after an `out_last` handshake.

## Test plan
- Ramp block 0..63 (LANES=1), `out_ready`=1 → `out_valid` first in cycle 94. Beats 0,1,2,63 = 0x00AD, 0xFFC1, 0x002A, 0x0000. `out_last` only on beat 63.
- Four back-to-back ramp blocks, `out_ready`=1 → `in_ready` never drops. Four identical 64-beat output blocks, spaced 64 cycles apart.
- `out_ready`=0 for 300 cycles while feeding 4 blocks → exactly 2 blocks launched. `in_ready` stays 0 after the third block fills. After releasing `out_ready`, all 4 blocks come out in order, bit-exact.
- LANES=4: ramp in 16 beats → launch in cycle 16. Output beat 0 = {0xFFED, 0x002A, 0xFFC1, 0x00AD} (lane 3..0). 16 output beats.
- `rst` pulsed in cycle 80, with one block in flight and a partial second block staged → no `out_valid` afterwards. `busy`=0. A fresh ramp block then yields the correct result at +94 cycles.
- Random `in_valid`/`out_ready` toggling (50%) over 20 blocks → results match the golden model. `credits` stays within 0..`OUT_BUFS`. No capture occurs into an occupied buffer.
